// File: rtl/console_pkg.sv
`default_nettype none
// ============================================================================
// Module   : console_pkg
// Brief    : Console window offsets, end-of-run magic, TX FSM states and
//            STATUS register layout shared by the console UART blocks.
// Revision : 1.0 - initial release
// ============================================================================
package console_pkg;

    // Word offsets within the console window, decoded on dbus_addr[3:2]
    localparam logic [1:0]  OFF_TXDATA = 2'd0;
    localparam logic [1:0]  OFF_STATUS = 2'd1;
    localparam logic [1:0]  OFF_EXIT   = 2'd2;

    localparam logic [31:0] FINI_MAGIC = 32'h0002_0000;

    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_FINI      = 3;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [31:0] pack_status(
        input logic       busy,
        input logic       full,
        input logic       empty,
        input logic       fini,
        input logic [7:0] count
    );
        logic [31:0] w_status;
        w_status                      = '0;
        w_status[ST_BUSY]             = busy;
        w_status[ST_FULL]             = full;
        w_status[ST_EMPTY]            = empty;
        w_status[ST_FINI]             = fini;
        w_status[ST_COUNT_LSB +: 8]   = count;
        return w_status;
    endfunction

endpackage
`default_nettype wire

// File: rtl/console_fifo.sv
`default_nettype none
// ============================================================================
// Module   : console_fifo
// Brief    : Synchronous show-ahead FIFO; rd_data_o presents the head entry.
// Revision : 1.0 - initial release
// ============================================================================
module console_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign w_wr = wr_en_i & ~full_o;
    assign w_rd = rd_en_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

    // Pointers are exactly log2(DEPTH) bits so they wrap without extra logic
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data_o = r_mem[r_rd_ptr];
    assign full_o    = r_count[c_AW];
    assign empty_o   = (r_count == '0);
    assign count_o   = r_count;

endmodule
`default_nettype wire

// File: rtl/console_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : console_uart_tx
// Brief    : Memory-mapped console: queues CPU stores and sends them as UART
//            8N1, and raises a sticky end-of-run flag on the magic/EXIT store.
// Revision : 1.0 - initial release
// ============================================================================
module console_uart_tx
    import console_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bus_sel_i,
    input  logic [3:0]  bus_addr_i,
    input  logic        bus_we_i,
    input  logic        bus_re_i,
    input  logic [31:0] bus_wdata_i,
    output logic [31:0] bus_rdata_o,
    output logic        bus_stall_o,
    output logic        txd_o,
    output logic        fini_o,
    output logic [31:0] exit_code_o
);

    localparam int c_CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int c_CNT_W        = (c_CLKS_PER_BIT > 1) ? $clog2(c_CLKS_PER_BIT) : 1;
    localparam int c_FIFO_AW      = $clog2(FIFO_DEPTH);

    logic [1:0]         w_off;
    logic               w_unused_addr;
    logic               w_txdata_st;
    logic               w_is_magic;
    logic               w_push_req;
    logic               w_fifo_wr;
    logic               w_exit_st;
    logic               w_fini_set;
    logic               w_status_rd;
    logic [31:0]        w_status;

    logic [7:0]         w_fifo_rdata;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [c_FIFO_AW:0] w_fifo_count;
    logic               w_pop;

    tx_state_e          r_state;
    tx_state_e          w_state_nxt;
    logic [c_CNT_W-1:0] r_baud_cnt;
    logic [c_CNT_W-1:0] w_baud_nxt;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;
    logic               r_txd;
    logic               w_txd_nxt;
    logic               w_baud_done;

    logic               r_fini;
    logic [31:0]        r_exit_code;
    logic [31:0]        r_rdata;

    // Bus decode
    assign w_off         = bus_addr_i[3:2];
    assign w_unused_addr = ^bus_addr_i[1:0];
    assign w_txdata_st   = bus_sel_i & bus_we_i & (w_off == OFF_TXDATA);
    assign w_is_magic    = (bus_wdata_i == FINI_MAGIC);
    assign w_push_req    = w_txdata_st & ~w_is_magic;
    assign w_fifo_wr     = w_push_req & ~w_fifo_full;
    assign w_exit_st     = bus_sel_i & bus_we_i & (w_off == OFF_EXIT);
    assign w_fini_set    = (w_txdata_st & w_is_magic) | w_exit_st;
    assign w_status_rd   = bus_sel_i & bus_re_i & (w_off == OFF_STATUS);

    // Stall looks only at current fullness, even if the FSM pops this cycle
    assign bus_stall_o   = w_push_req & w_fifo_full;

    console_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (w_fifo_wr),
        .wr_data_i (bus_wdata_i[7:0]),
        .rd_en_i   (w_pop),
        .rd_data_o (w_fifo_rdata),
        .full_o    (w_fifo_full),
        .empty_o   (w_fifo_empty),
        .count_o   (w_fifo_count)
    );

    assign w_status = pack_status(r_state != TX_IDLE, w_fifo_full, w_fifo_empty,
                                  r_fini, 8'(w_fifo_count));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fini      <= 1'b0;
            r_exit_code <= '0;
            r_rdata     <= '0;
        end else begin
            if (w_fini_set) begin
                r_fini <= 1'b1;
            end
            if (w_exit_st) begin
                r_exit_code <= bus_wdata_i;
            end
            r_rdata <= w_status_rd ? w_status : 32'h0;
        end
    end

    assign w_baud_done = (r_baud_cnt == c_CNT_W'(c_CLKS_PER_BIT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= TX_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_txd      <= w_txd_nxt;
        end
    end

    // STOP chains straight into START so back-to-back frames have no idle gap
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        w_txd_nxt   = 1'b1;
        unique case (r_state)
            TX_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_rdata;
                    w_baud_nxt  = '0;
                    w_state_nxt = TX_START;
                end
            end
            TX_START: begin
                if (w_baud_done) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = TX_DATA;
                end else begin
                    w_baud_nxt = r_baud_cnt + c_CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (w_baud_done) begin
                    w_baud_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = TX_STOP;
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + c_CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (w_baud_done) begin
                    w_baud_nxt = '0;
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_fifo_rdata;
                        w_state_nxt = TX_START;
                    end else begin
                        w_state_nxt = TX_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = TX_IDLE;
            end
        endcase
        case (w_state_nxt)
            TX_START: w_txd_nxt = 1'b0;
            TX_DATA:  w_txd_nxt = w_shift_nxt[w_bit_nxt];
            default:  w_txd_nxt = 1'b1;
        endcase
    end

    assign txd_o       = r_txd;
    assign fini_o      = r_fini;
    assign exit_code_o = r_exit_code;
    assign bus_rdata_o = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_console_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_console_uart_tx
// Brief    : Directed + randomized bench for console_uart_tx with a UART
//            receiver model and an expected-byte queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_console_uart_tx;

    localparam int          CPB   = 4;
    localparam int          FRAME = 10 * CPB;
    localparam logic [31:0] MAGIC = 32'h0002_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        bus_sel_i = 1'b0;
    logic [3:0]  bus_addr_i = 4'h0;
    logic        bus_we_i = 1'b0;
    logic        bus_re_i = 1'b0;
    logic [31:0] bus_wdata_i = 32'h0;
    logic [31:0] bus_rdata_o;
    logic        bus_stall_o;
    logic        txd_o;
    logic        fini_o;
    logic [31:0] exit_code_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] rx_q[$];
    int         rx_start[$];
    int         rx_ferr = 0;

    logic [7:0] exp_q[$];
    int         rx_chk = 0;

    console_uart_tx #(
        .CLK_FREQ_HZ (400),
        .BAUD_RATE   (100),
        .FIFO_DEPTH  (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus_sel_i   (bus_sel_i),
        .bus_addr_i  (bus_addr_i),
        .bus_we_i    (bus_we_i),
        .bus_re_i    (bus_re_i),
        .bus_wdata_i (bus_wdata_i),
        .bus_rdata_o (bus_rdata_o),
        .bus_stall_o (bus_stall_o),
        .txd_o       (txd_o),
        .fini_o      (fini_o),
        .exit_code_o (exit_code_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Receiver: detect start at bit offset 0, sample each bit at offset 1
    initial begin : rx_mon
        logic [7:0] b;
        int         st;
        b = 8'h00;
        forever begin
            @(negedge clk_i);
            if (!rst_i && txd_o === 1'b0) begin
                st = cyc;
                @(negedge clk_i);
                if (txd_o !== 1'b0) rx_ferr++;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk_i);
                    b[i] = txd_o;
                end
                repeat (CPB) @(negedge clk_i);
                if (txd_o !== 1'b1) rx_ferr++;
                rx_q.push_back(b);
                rx_start.push_back(st);
                repeat (CPB - 2) @(negedge clk_i);
            end
        end
    end

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus_sel_i   = 1'b0;
        bus_we_i    = 1'b0;
        bus_re_i    = 1'b0;
        bus_addr_i  = 4'h0;
        bus_wdata_i = 32'h0;
    endtask

    // Holds the store until accepted; returns stalled cycles and acceptance edge
    task automatic store_word(input logic [3:0] a, input logic [31:0] d,
                              output int stalls, output int acc);
        bus_sel_i   = 1'b1;
        bus_we_i    = 1'b1;
        bus_re_i    = 1'b0;
        bus_addr_i  = a;
        bus_wdata_i = d;
        stalls      = 0;
        forever begin
            @(negedge clk_i);
            if (!bus_stall_o) break;
            stalls++;
            if (stalls > 500) begin
                $display("FAIL store_timeout: stall held %0d cycles, required release", stalls);
                $fatal(1, "store timeout");
            end
        end
        @(posedge clk_i);
        #1;
        acc = cyc;
    endtask

    task automatic load_word(input logic [3:0] a, output logic [31:0] d);
        bus_idle();
        bus_sel_i  = 1'b1;
        bus_re_i   = 1'b1;
        bus_addr_i = a;
        @(posedge clk_i);
        #1;
        bus_idle();
        d = bus_rdata_o;
    endtask

    function automatic logic [31:0] rand_word(input logic [7:0] lo);
        logic [31:0] w;
        w = $urandom();
        w[7:0] = lo;
        if (w == MAGIC) w[8] = 1'b1;
        return w;
    endfunction

    // Waits until every expected byte arrived, then compares in order
    task automatic drain(input string tag);
        int n;
        int waited;
        n = exp_q.size();
        waited = 0;
        while (rx_q.size() < rx_chk + n && waited < 2000) begin
            @(negedge clk_i);
            waited++;
        end
        check({tag, "_count"}, 32'(rx_q.size() - rx_chk), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (rx_chk + i < rx_q.size())
                check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[rx_chk + i]), 32'(exp_q[i]));
        end
        rx_chk = rx_q.size();
        exp_q.delete();
        repeat (CPB) @(posedge clk_i);
        #1;
    endtask

    initial begin : main
        int          st;
        int          acc;
        int          acc_first;
        int          errs;
        int          base;
        int          n;
        int          lows;
        logic [9:0]  frame;
        logic        expb;
        logic [7:0]  by;
        logic [31:0] rd;

        bus_idle();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("reset_txd", 32'(txd_o), 32'd1);
        check("reset_fini", 32'(fini_o), 32'd0);
        check("reset_exit", exit_code_o, 32'h0);
        check("reset_rdata", bus_rdata_o, 32'h0);
        check("reset_stall", 32'(bus_stall_o), 32'd0);
        load_word(4'h4, rd);
        check("reset_status", rd, 32'h0000_0004);

        // Single 0x41 frame, checked sample by sample against the 8N1 shape
        store_word(4'h0, 32'h0000_0041, st, acc);
        bus_idle();
        frame = {1'b1, 8'h41, 1'b0};
        errs = 0;
        for (int j = 0; j <= FRAME + 1; j++) begin
            @(negedge clk_i);
            if (j == 0 || j == FRAME + 1) expb = 1'b1;
            else expb = frame[(j - 1) / CPB];
            if (txd_o !== expb) errs++;
        end
        check("frame41_wave_errs", 32'(errs), 32'd0);
        exp_q.push_back(8'h41);
        drain("frame41");

        // Four back-to-back stores then STATUS: three queued, one in flight
        base = rx_q.size();
        for (int i = 0; i < 4; i++) begin
            by = 8'($urandom());
            exp_q.push_back(by);
            store_word(4'h0, rand_word(by), st, acc);
        end
        load_word(4'h4, rd);
        check("status_3q_busy", rd, 32'h0000_0301);
        drain("burst4");
        for (int i = 0; i < 3; i++)
            check($sformatf("burst4_gap%0d", i), 32'(rx_start[base + i + 1] - rx_start[base + i]), 32'(FRAME));

        // 18 stores into a 16-deep FIFO: the 18th waits for the first frame to end
        base = rx_q.size();
        acc_first = 0;
        for (int i = 0; i < 18; i++) begin
            by = 8'($urandom());
            exp_q.push_back(by);
            store_word(4'h0, rand_word(by), st, acc);
            if (i == 0) acc_first = acc;
            if (i > 0 && i < 17) check($sformatf("flood_nostall%0d", i), 32'(st), 32'd0);
            if (i == 17) begin
                check("flood_stall_cycles", 32'(st), 32'(FRAME + 1 - 16));
                check("flood_accept_edge", 32'(acc - acc_first), 32'(1 + FRAME + 1));
            end
        end
        bus_idle();
        drain("flood");
        errs = 0;
        for (int i = 0; i < 17; i++)
            if (rx_start[base + i + 1] - rx_start[base + i] != FRAME) errs++;
        check("flood_gaps", 32'(errs), 32'd0);

        // Random bursts with random idle gaps
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(3, 24);
            for (int i = 0; i < n; i++) begin
                by = 8'($urandom());
                exp_q.push_back(by);
                store_word(4'h0, rand_word(by), st, acc);
                bus_idle();
                repeat ($urandom_range(0, 3)) @(posedge clk_i);
                #1;
            end
            drain($sformatf("rand%0d", r));
        end
        check("frame_errors", 32'(rx_ferr), 32'd0);

        // Magic store: flag only, nothing enqueued
        check("pre_magic_fini", 32'(fini_o), 32'd0);
        base = rx_q.size();
        store_word(4'h0, MAGIC, st, acc);
        bus_idle();
        check("magic_fini", 32'(fini_o), 32'd1);
        load_word(4'h4, rd);
        check("magic_status", rd, 32'h0000_000C);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (txd_o !== 1'b1) lows++;
        end
        check("magic_txd_idle", 32'(lows), 32'd0);
        check("magic_no_frame", 32'(rx_q.size() - base), 32'd0);

        // Reserved store ignored; write-only and reserved loads read zero
        store_word(4'hC, 32'h0000_0077, st, acc);
        bus_idle();
        load_word(4'h4, rd);
        check("rsvd_store_status", rd, 32'h0000_000C);
        load_word(4'hC, rd);
        check("rsvd_load", rd, 32'h0);
        load_word(4'h0, rd);
        check("txdata_load", rd, 32'h0);

        store_word(4'h8, 32'hDEAD_BEEF, st, acc);
        bus_idle();
        check("exit_code", exit_code_o, 32'hDEAD_BEEF);
        check("exit_fini", 32'(fini_o), 32'd1);
        load_word(4'h8, rd);
        check("exit_load", rd, 32'h0);
        load_word(4'h4, rd);
        check("exit_status", rd, 32'h0000_000C);

        // Output keeps draining after fini
        exp_q.push_back(8'h5A);
        store_word(4'h0, 32'h0000_005A, st, acc);
        bus_idle();
        drain("post_fini");

        // Reset in the middle of the data bits of a 0x00 frame
        store_word(4'h0, 32'h0000_0000, st, acc);
        bus_idle();
        repeat (12) @(posedge clk_i);
        #2;
        check("mid_data_txd_low", 32'(txd_o), 32'd0);
        rst_i = 1'b1;
        #1;
        check("async_rst_txd", 32'(txd_o), 32'd1);
        check("async_rst_fini", 32'(fini_o), 32'd0);
        check("async_rst_exit", exit_code_o, 32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        load_word(4'h4, rd);
        check("post_rst_status", rd, 32'h0000_0004);
        repeat (60) @(posedge clk_i);
        #1;
        rx_chk = rx_q.size();
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            if (txd_o !== 1'b1) lows++;
        end
        check("post_rst_txd_idle", 32'(lows), 32'd0);
        check("post_rst_no_frame", 32'(rx_q.size() - rx_chk), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
